// File: rtl/decode2_uop_sequencer_if.sv
// decode2_uop_sequencer_if
//   Bundles the decode-stage-2 handshake and control-store bus for the
//   micro-op sequencer.
//   master : stage-1 / control-store side (drives instruction + cs fields)
//   slave  : the sequencer (drives cs address, micro-op tags, stall, EIP_OUT)
//   Signals: D2_V, flush, stall_in, decode_address, opcode_size,
//            instr_length_updt, EIP, cs_uop_stall, cs_next_uaddr  (to seq)
//            cs_addr, cs_op_size, uop_valid, uop_index, uop_first, uop_last,
//            D2_UOP_STALL_OUT, EIP_OUT, uop_overflow          (from seq)
interface decode2_uop_sequencer_if #(
  parameter int UADDR_W = 8,
  parameter int LEN_W   = 4,
  parameter int EIP_W   = 32
);
  logic               D2_V;
  logic               flush;
  logic               stall_in;
  logic [UADDR_W-1:0] decode_address;
  logic               opcode_size;
  logic [LEN_W-1:0]   instr_length_updt;
  logic [EIP_W-1:0]   EIP;
  logic               cs_uop_stall;
  logic [UADDR_W-2:0] cs_next_uaddr;

  logic [UADDR_W-1:0] cs_addr;
  logic               cs_op_size;
  logic               uop_valid;
  logic [3:0]         uop_index;
  logic               uop_first;
  logic               uop_last;
  logic               D2_UOP_STALL_OUT;
  logic [EIP_W-1:0]   EIP_OUT;
  logic               uop_overflow;

  modport master (
    output D2_V, flush, stall_in, decode_address, opcode_size,
           instr_length_updt, EIP, cs_uop_stall, cs_next_uaddr,
    input  cs_addr, cs_op_size, uop_valid, uop_index, uop_first, uop_last,
           D2_UOP_STALL_OUT, EIP_OUT, uop_overflow
  );

  modport slave (
    input  D2_V, flush, stall_in, decode_address, opcode_size,
           instr_length_updt, EIP, cs_uop_stall, cs_next_uaddr,
    output cs_addr, cs_op_size, uop_valid, uop_index, uop_first, uop_last,
           D2_UOP_STALL_OUT, EIP_OUT, uop_overflow
  );
endinterface

// File: rtl/decode2_uop_sequencer.sv
// decode2_uop_sequencer
//   Expands one decoded instruction into 1..MAX_UOPS control-store micro-ops.
//   First micro-op address comes from decode_address; later ones from the
//   registered cs_next_uaddr field. Holds stage 1 while a sequence is in
//   flight, tags micro-ops (index/first/last), advances EIP on the last one.
//   Ports:
//     clk, reset   : clock, synchronous active-high reset
//     d2_bus       : decode2_uop_sequencer_if.slave (handshake + cs bus)
//     perf_uops    : (D2_UOP_PERF_EN only) issued micro-op count
//     perf_instrs  : (D2_UOP_PERF_EN only) completed instruction count
//   Optional feature macro: D2_UOP_PERF_EN
//   MAX_UOPS must lie in 2..16 (uop_index is 4 bits).
module decode2_uop_sequencer #(
  parameter int UADDR_W  = 8,
  parameter int MAX_UOPS = 4,
  parameter int LEN_W    = 4,
  parameter int EIP_W    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  decode2_uop_sequencer_if.slave       d2_bus
`ifdef D2_UOP_PERF_EN
  ,
  output logic [31:0]                  perf_uops,
  output logic [31:0]                  perf_instrs
`endif
);

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_SEQ   = 1'b1
  } state_t;

  state_t             r_state;
  logic [3:0]         r_count;
  logic [UADDR_W-2:0] r_next_uaddr;
  logic               r_overflow;

  logic w_advance;
  logic w_at_max;
  logic w_last;

  assign w_advance = d2_bus.D2_V & ~d2_bus.stall_in & ~d2_bus.flush;
  assign w_at_max  = (r_count == 4'(MAX_UOPS - 1));
  // Reaching the last slot forces termination even if the control store
  // still requests more micro-ops.
  assign w_last    = ~d2_bus.cs_uop_stall | w_at_max;

  // Address mux depends only on state and stage-1 inputs, never on stall_in.
  assign d2_bus.cs_addr          = (r_state == ST_FIRST) ? d2_bus.decode_address
                                                         : {1'b0, r_next_uaddr};
  assign d2_bus.cs_op_size       = (r_state == ST_FIRST) ? d2_bus.opcode_size : 1'b0;
  assign d2_bus.uop_valid        = w_advance;
  assign d2_bus.uop_index        = r_count;
  assign d2_bus.uop_first        = (r_state == ST_FIRST);
  assign d2_bus.uop_last         = w_last;
  assign d2_bus.D2_UOP_STALL_OUT = d2_bus.D2_V & ~w_last & ~d2_bus.flush;
  assign d2_bus.EIP_OUT          = w_last ? d2_bus.EIP + EIP_W'(d2_bus.instr_length_updt)
                                          : d2_bus.EIP;
  assign d2_bus.uop_overflow     = r_overflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_FIRST;
      r_count      <= '0;
      r_next_uaddr <= '0;
      r_overflow   <= 1'b0;
    end else if (d2_bus.flush) begin
      // Flush abandons the sequence but keeps the sticky overflow flag.
      r_state <= ST_FIRST;
      r_count <= '0;
    end else if (w_advance) begin
      if (!w_last) begin
        r_next_uaddr <= d2_bus.cs_next_uaddr;
        r_count      <= r_count + 4'd1;
        r_state      <= ST_SEQ;
      end else begin
        r_count <= '0;
        r_state <= ST_FIRST;
        if ((r_state == ST_SEQ) && w_at_max && d2_bus.cs_uop_stall)
          r_overflow <= 1'b1;
      end
    end
  end

`ifdef D2_UOP_PERF_EN
  logic [31:0] r_perf_uops;
  logic [31:0] r_perf_instrs;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_uops   <= '0;
      r_perf_instrs <= '0;
    end else if (w_advance) begin
      r_perf_uops <= r_perf_uops + 32'd1;
      if (w_last)
        r_perf_instrs <= r_perf_instrs + 32'd1;
    end
  end

  assign perf_uops   = r_perf_uops;
  assign perf_instrs = r_perf_instrs;
`endif

endmodule

// File: doc/decode2_uop_sequencer.md
Name: decode2_uop_sequencer

Overview:
Parametrised micro-op sequencer for decode stage 2. It expands one decoded x86 instruction into 1..MAX_UOPS control-store micro-ops. The first micro-op address comes from decode_address. Each later address is the control store's next-micro-address field, registered. The block drives the control-store address/op-size mux, holds decode stage 1 while a sequence is in flight, tags each micro-op (index, first, last) and advances EIP only on the last micro-op.

Parameters:
UADDR_W, 8, control-store address width (bit UADDR_W-1 selects the opcode page; next-address field is UADDR_W-1 bits, zero-extended)
MAX_UOPS, 4, maximum micro-ops per instruction (2..16)
LEN_W, 4, instruction length field width
EIP_W, 32, instruction pointer width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
D2_V  in  1  valid instruction present in decode stage 2
flush  in  1  pipeline flush (branch/exception); synchronous
stall_in  in  1  downstream (AG) not accepting this cycle
decode_address  in  UADDR_W  first micro-op address from stage 1
opcode_size  in  1  0 = one-byte map, 1 = 0F map
instr_length_updt  in  LEN_W  instruction length in bytes
EIP  in  EIP_W  instruction start EIP
cs_uop_stall  in  1  control-store bit of current micro-op: more micro-ops follow
cs_next_uaddr  in  UADDR_W-1  control-store next micro-op address
cs_addr  out  UADDR_W  control-store address for this cycle
cs_op_size  out  1  control-store opcode page select
uop_valid  out  1  micro-op issued to AG this cycle (D2_V & !flush & !stall_in)
uop_index  out  4  ordinal of current micro-op, 0-based
uop_first  out  1  current micro-op is the first of the instruction
uop_last  out  1  current micro-op is the last of the instruction
D2_UOP_STALL_OUT  out  1  hold stage 1 and the stage-2 latch (sequence not complete)
EIP_OUT  out  EIP_W  EIP of next instruction on last micro-op, else EIP
uop_overflow  out  1  sticky: sequence hit MAX_UOPS with cs_uop_stall still set

Behaviour:
- Reset, synchronous at the clk edge: state=FIRST, count=0, next-address register=0, uop_overflow=0. All combinational outputs follow from this state.
- States:
  - FIRST: cs_addr=decode_address, cs_op_size=opcode_size.
  - SEQ: cs_addr={1'b0, next-address register}, cs_op_size=0.
- uop_index=count. uop_first=(state==FIRST).
- uop_last = !cs_uop_stall | (count==MAX_UOPS-1).
- An "advance" occurs when D2_V & !stall_in & !flush.
- FIRST, on advance:
  - If !uop_last: latch cs_next_uaddr, count<=1, go to SEQ.
  - Else: stay in FIRST with count=0.
- SEQ, on advance:
  - If !uop_last: latch cs_next_uaddr, count<=count+1, stay in SEQ.
  - Else: count<=0, go to FIRST.
- No advance (stall_in or !D2_V): all state holds, and outputs stay stable for the re-presented micro-op.
- D2_UOP_STALL_OUT = D2_V & !uop_last & !flush.
  - Combinational; stage 1 must not advance in the same cycle.
  - The stall_in backpressure is OR'ed with it by the pipeline controller, not here.
- EIP_OUT = uop_last ? EIP + zero_extend(instr_length_updt) : EIP, modulo 2^EIP_W (FFFFFFFF+1 wraps to 0, no carry out).
- Overflow: in SEQ with count==MAX_UOPS-1 and cs_uop_stall=1, the micro-op is forced last and state returns to FIRST. uop_overflow is set and stays set until reset.
- flush has priority over advance: state<=FIRST, count<=0, and uop_valid=0 that cycle. It applies mid-sequence in SEQ or in FIRST; uop_overflow is kept. flush together with reset behaves as reset.
- D2_V deasserted mid-sequence (bubble): state holds and no micro-op issues. Sequencing resumes when D2_V returns.
- All registered state updates occur only on the clk edge. There is no combinational path from stall_in to cs_addr.

Optional Feature:
D2_UOP_PERF_EN: when defined, adds outputs perf_uops[31:0] and perf_instrs[31:0].
- perf_uops increments on every uop_valid; perf_instrs increments on every uop_valid & uop_last.
- Both cleared by reset, wrap at 2^32, and do not increment under flush or stall_in.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single micro-op: reset; D2_V=1, decode_address=8'h3C, cs_uop_stall=0, EIP=32'h1000, len=3. Required: cs_addr=3C, uop_first=uop_last=1, EIP_OUT=32'h1003, D2_UOP_STALL_OUT=0, state stays FIRST.
- Three micro-ops: decode_address=8'h42, cs_uop_stall=1,1,0, cs_next_uaddr=7'h50 then 7'h51, EIP=32'h2000, len=5. Required: cs_addr sequence 42,50,51; uop_index 0,1,2; D2_UOP_STALL_OUT=1,1,0; EIP_OUT=2000,2000,2005.
- Backpressure: in the 3-micro-op case hold stall_in=1 for 2 cycles on micro-op 1. Required: cs_addr stays 50 and uop_valid=0 for 2 cycles, then sequence resumes 50→51 and no micro-op is skipped.
- Flush mid-sequence: flush=1 while in SEQ at count=1. Required: uop_valid=0 that cycle; next cycle state FIRST, cs_addr=decode_address, uop_index=0.
- Overflow (MAX_UOPS=4): cs_uop_stall held at 1. Required: 4th micro-op has uop_last=1; uop_overflow=1 afterwards and stays 1 across a flush; reset clears it.
- EIP wrap: EIP=32'hFFFFFFFE, len=4, single micro-op. Required: EIP_OUT=32'h00000002. With D2_UOP_PERF_EN: perf_uops/perf_instrs counts match the issued micro-ops/instructions after the above sequences.
